// File: rtl/bus_trace_pkg.sv
// Shared constants, trigger state type and clog2 helper for the bus trace monitor.
package bus_trace_pkg;

    localparam int DEF_BUS_W = 8;
    localparam int DEF_TS_W  = 16;
    localparam int ENTRY_W   = DEF_TS_W + DEF_BUS_W;
    localparam int DROP_W    = 8;

    typedef enum logic {
        TRIG_ARMED = 1'b0,
        TRIG_RUN   = 1'b1
    } trig_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_trace_if.sv
// Trace drain port: valid/ready handshake carrying {timestamp, bus value} entries.
interface bus_trace_if #(
    parameter int ENTRY_W = bus_trace_pkg::ENTRY_W
) ();

    logic               out_valid;
    logic               out_ready;
    logic [ENTRY_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/bus_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is presented on dout while not empty.
module bus_trace_fifo
    import bus_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted when a pop frees the head slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/bus_trace_monitor.sv
// Timestamps every change of the monitored bus into a trace FIFO drained over a valid/ready port.
// Optional start trigger enabled by defining BUS_TRACE_TRIG_EN.
module bus_trace_monitor
    import bus_trace_pkg::*;
#(
    parameter int BUS_W = 8,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_W-1:0]      bus_in,
    input  logic                  enable,
`ifdef BUS_TRACE_TRIG_EN
    input  logic [BUS_W-1:0]      trig_val,
    output logic                  armed,
`endif
    bus_trace_if.master           trace,
    output logic [clog2(DEPTH):0] level,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_cnt
);

    localparam int EW = TS_W + BUS_W;

    logic [TS_W-1:0]  ts;
    logic [BUS_W-1:0] prev;
    logic             primed;
    logic             changed;
    logic             want_push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;

    // primed masks the first edge after reset, which only loads prev.
    assign changed = primed && enable && (bus_in != prev);
    assign pop     = trace.out_valid && trace.out_ready;

`ifdef BUS_TRACE_TRIG_EN
    trig_state_t state;
    trig_state_t state_nxt;
    logic        trig_hit;

    assign trig_hit = primed && enable && (bus_in == trig_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TRIG_ARMED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == TRIG_ARMED && trig_hit) begin
            state_nxt = TRIG_RUN;
        end
    end

    // The trigger value itself is captured even when it equals prev.
    always_comb begin
        armed     = (state == TRIG_ARMED);
        want_push = armed ? trig_hit : changed;
    end
`else
    assign want_push = changed;
`endif

    assign drop = want_push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            prev     <= '0;
            primed   <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ts     <= ts + 1'b1;
            prev   <= bus_in;
            primed <= 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    bus_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (want_push),
        .din   ({ts, bus_in}),
        .pop   (pop),
        .dout  (trace.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign trace.out_valid = !fifo_empty;

endmodule

// File: tb/tb_bus_trace_monitor.sv
// Bench for bus_trace_monitor: two instances (16-deep/16-bit ts and 4-deep/4-bit ts) against a queue model.
module tb_bus_trace_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_in = 8'h00;
    logic       enable = 1'b0;
    logic       out_ready = 1'b0;
`ifdef BUS_TRACE_TRIG_EN
    logic [7:0] trig_val = 8'h00;
    logic       armed0;
    logic       armed1;
`endif

    logic [4:0] level0;
    logic [2:0] level1;
    logic       ovf0;
    logic       ovf1;
    logic [7:0] drop0;
    logic [7:0] drop1;

    int n_checks = 0;
    int n_fail   = 0;

    bus_trace_if #(.ENTRY_W(24)) t0 ();
    bus_trace_if #(.ENTRY_W(12)) t1 ();
    assign t0.out_ready = out_ready;
    assign t1.out_ready = out_ready;

    always #5 clk = ~clk;

    bus_trace_monitor #(.BUS_W(8), .DEPTH(16), .TS_W(16)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .bus_in   (bus_in),
        .enable   (enable),
`ifdef BUS_TRACE_TRIG_EN
        .trig_val (trig_val),
        .armed    (armed0),
`endif
        .trace    (t0),
        .level    (level0),
        .overflow (ovf0),
        .drop_cnt (drop0)
    );

    bus_trace_monitor #(.BUS_W(8), .DEPTH(4), .TS_W(4)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .bus_in   (bus_in),
        .enable   (enable),
`ifdef BUS_TRACE_TRIG_EN
        .trig_val (trig_val),
        .armed    (armed1),
`endif
        .trace    (t1),
        .level    (level1),
        .overflow (ovf1),
        .drop_cnt (drop1)
    );

    // Reference model: one entry queue per instance, entries stored as (ts << 8) | value.
    logic [31:0] mq [2][$];
    int m_ts    [2];
    int m_prev  [2];
    int m_primed[2];
    int m_ovf   [2];
    int m_drop  [2];
    int m_armed [2];

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 4;
    endfunction

    function automatic int ts_mask(input int d);
        return (d == 0) ? 32'h0000_FFFF : 32'h0000_000F;
    endfunction

    task automatic model_step(input int d);
        bit pop;
        bit want;
        int sz;
        if (rst) begin
            mq[d].delete();
            m_ts[d] = 0; m_prev[d] = 0; m_primed[d] = 0;
            m_ovf[d] = 0; m_drop[d] = 0; m_armed[d] = 1;
        end else begin
            sz   = mq[d].size();
            pop  = (sz > 0) && out_ready;
            want = (m_primed[d] != 0) && enable && (int'(bus_in) != m_prev[d]);
`ifdef BUS_TRACE_TRIG_EN
            if (m_armed[d] != 0) begin
                want = (m_primed[d] != 0) && enable && (bus_in == trig_val);
                if (want) m_armed[d] = 0;
            end
`endif
            if (pop) void'(mq[d].pop_front());
            if (want) begin
                if (sz < depth_of(d) || pop) begin
                    mq[d].push_back(32'(((m_ts[d] & ts_mask(d)) << 8) | int'(bus_in)));
                end else begin
                    m_ovf[d] = 1;
                    if (m_drop[d] < 255) m_drop[d]++;
                end
            end
            m_prev[d]   = int'(bus_in);
            m_primed[d] = 1;
            m_ts[d]     = (m_ts[d] + 1) & ts_mask(d);
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_head(input int d);
        return (mq[d].size() > 0) ? mq[d][0] : 32'h0;
    endfunction

    task automatic compare_model();
        check_eq("valid0", 32'(t0.out_valid), 32'(mq[0].size() > 0));
        check_eq("data0",  32'(t0.out_data),  model_head(0));
        check_eq("level0", 32'(level0),       32'(mq[0].size()));
        check_eq("ovf0",   32'(ovf0),         32'(m_ovf[0]));
        check_eq("drop0",  32'(drop0),        32'(m_drop[0]));
        check_eq("valid1", 32'(t1.out_valid), 32'(mq[1].size() > 0));
        check_eq("data1",  32'(t1.out_data),  model_head(1));
        check_eq("level1", 32'(level1),       32'(mq[1].size()));
        check_eq("ovf1",   32'(ovf1),         32'(m_ovf[1]));
        check_eq("drop1",  32'(drop1),        32'(m_drop[1]));
`ifdef BUS_TRACE_TRIG_EN
        check_eq("armed0", 32'(armed0), 32'(m_armed[0]));
        check_eq("armed1", 32'(armed1), 32'(m_armed[1]));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // After this returns, the next clock edge processes the cycle with ts == 0.
    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        enable    = 1'b1;
        out_ready = 1'b0;
        bus_in    = 8'h00;
        cycle();
        cycle();
        check_eq("rst_valid", 32'(t0.out_valid), 32'h0);
        check_eq("rst_data",  32'(t0.out_data),  32'h0);
        check_eq("rst_level", 32'(level0),       32'h0);
        check_eq("rst_ovf",   32'(ovf0),         32'h0);
        check_eq("rst_drop",  32'(drop0),        32'h0);
        rst = 1'b0;
        repeat (20) begin
            cycle();
            check_eq("idle_valid", 32'(t0.out_valid), 32'h0);
            check_eq("idle_level", 32'(level0),       32'h0);
        end

`ifndef BUS_TRACE_TRIG_EN
        // Two isolated changes at ts=5 and ts=9, drained immediately.
        do_reset();
        out_ready = 1'b1;
        repeat (5) cycle();
        bus_in = 8'h3C;
        cycle();
        check_eq("chg1_valid", 32'(t0.out_valid), 32'h1);
        check_eq("chg1_data",  32'(t0.out_data),  {8'h0, 16'd5, 8'h3C});
        repeat (3) cycle();
        check_eq("chg1_gone", 32'(t0.out_valid), 32'h0);
        bus_in = 8'hA5;
        cycle();
        check_eq("chg2_data", 32'(t0.out_data), {8'h0, 16'd9, 8'hA5});

        // Fill past full with the host stalled.
        do_reset();
        out_ready = 1'b0;
        bus_in    = 8'h00;
        cycle();
        for (int i = 0; i < 20; i++) begin
            bus_in = ~bus_in;
            cycle();
        end
        check_eq("full_level0", 32'(level0), 32'd16);
        check_eq("full_ovf0",   32'(ovf0),   32'h1);
        check_eq("full_drop0",  32'(drop0),  32'd4);
        check_eq("full_head0",  32'(t0.out_data), {8'h0, 16'd1, 8'hFF});
        check_eq("full_level1", 32'(level1), 32'd4);
        check_eq("full_drop1",  32'(drop1),  32'd16);

        // Change coinciding with a pop while full: no drop, entry lands at the tail.
        out_ready = 1'b1;
        bus_in    = 8'h77;
        cycle();
        check_eq("pp_level0", 32'(level0), 32'd16);
        check_eq("pp_drop0",  32'(drop0),  32'd4);
        check_eq("pp_head0",  32'(t0.out_data), {8'h0, 16'd2, 8'h00});
        check_eq("pp_drop1",  32'(drop1),  32'd16);
        repeat (15) cycle();
        check_eq("pp_tail_level", 32'(level0), 32'd1);
        check_eq("pp_tail_val",   32'(t0.out_data[7:0]), 32'h77);
        cycle();
        check_eq("pp_drained", 32'(t0.out_valid), 32'h0);

        // Timestamp wrap on the 4-bit instance.
        do_reset();
        out_ready = 1'b1;
        bus_in    = 8'h00;
        repeat (15) cycle();
        bus_in = 8'h01;
        cycle();
        check_eq("wrap_ts15", 32'(t1.out_data), {20'h0, 4'd15, 8'h01});
        bus_in = 8'h02;
        cycle();
        check_eq("wrap_ts0",  32'(t1.out_data), {20'h0, 4'd0, 8'h02});
        check_eq("wide_ts16", 32'(t0.out_data), {8'h0, 16'd16, 8'h02});
`else
        do_reset();
        trig_val  = 8'h42;
        out_ready = 1'b0;
        bus_in    = 8'h11;
        cycle();
        check_eq("trig_armed", 32'(armed0), 32'h1);
        bus_in = 8'h22;
        cycle();
        check_eq("trig_blocked", 32'(level0), 32'h0);
        bus_in = 8'h42;
        cycle();
        check_eq("trig_disarm", 32'(armed0), 32'h0);
        check_eq("trig_first",  32'(t0.out_data[7:0]), 32'h42);
        bus_in = 8'h43;
        cycle();
        check_eq("trig_level", 32'(level0), 32'd2);
`endif

        // Drop counter saturation.
        do_reset();
        out_ready = 1'b0;
        bus_in    = 8'h00;
        cycle();
        for (int i = 0; i < 300; i++) begin
            bus_in = ~bus_in;
            cycle();
        end
`ifndef BUS_TRACE_TRIG_EN
        check_eq("sat_drop0", 32'(drop0), 32'd255);
        check_eq("sat_drop1", 32'(drop1), 32'd255);
`endif

        // Randomised traffic, including mid-run resets and enable gaps.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 399) == 0);
            bus_in    = 8'($urandom_range(0, 3)) | ((i >= 1500) ? 8'h40 : 8'h00);
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
`ifdef BUS_TRACE_TRIG_EN
            trig_val  = 8'($urandom_range(0, 3)) | ((i >= 1500) ? 8'h40 : 8'h00);
`endif
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
